// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: opcodes, FSM states,
// datapath mux encodings and the decoded control bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: known = 1'b1;
      default:                                       known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mc_control.sv
// Moore FSM sequencing the shared-memory multicycle MIPS datapath.
// All outputs are held at zero while reset is low.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       halted
);

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_s;
  ctrl_t  gated_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; opcode only matters in DECODE and MEMADR
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              next_state_s = S_HALT;
            end else begin
              next_state_s = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMRD:  next_state_s = S_MEMWB;
      S_EXEC:   next_state_s = S_ALUWB;
      S_ADDIEX: next_state_s = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Per-state control decode
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      S_FETCH: begin
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_src    = PCSRC_ALU;
        ctrl_s.ir_write  = 1'b1;
        ctrl_s.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b  = SRCB_IMMSH2;
        ctrl_s.instr_done = !HALT_ON_ILLEGAL && !is_known_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl_s.iord = 1'b1;
      S_MEMWB: begin
        ctrl_s.memto_reg  = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_s.iord       = 1'b1;
        ctrl_s.mem_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REGB;
        ctrl_s.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a  = 1'b1;
        ctrl_s.alu_src_b  = SRCB_REGB;
        ctrl_s.alu_op     = ALUOP_SUB;
        ctrl_s.pc_src     = PCSRC_ALUOUT;
        ctrl_s.branch     = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pc_src     = PCSRC_JUMP;
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_HALT:  ctrl_s.halted = 1'b1;
      default: ctrl_s = '0;
    endcase
  end

  // Force every output low while reset is held, independent of state
  always_comb begin
    if (reset) begin
      gated_s = ctrl_s;
    end else begin
      gated_s = '0;
    end
  end

  assign pc_en      = gated_s.pc_write | (gated_s.branch & zero);
  assign iord       = gated_s.iord;
  assign mem_write  = gated_s.mem_write;
  assign ir_write   = gated_s.ir_write;
  assign reg_dst    = gated_s.reg_dst;
  assign memto_reg  = gated_s.memto_reg;
  assign reg_write  = gated_s.reg_write;
  assign alu_src_a  = gated_s.alu_src_a;
  assign alu_src_b  = gated_s.alu_src_b;
  assign alu_op     = gated_s.alu_op;
  assign pc_src     = gated_s.pc_src;
  assign instr_done = gated_s.instr_done;
  assign halted     = gated_s.halted;

endmodule
